// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared widths, core latency and FSM encodings for the Blink scheduler
package blink_pkg;
    localparam int N        = 64;   // block width
    localparam int TW       = 64;   // tweak width
    localparam int KW       = 448;  // round-key bundle width (N*ROUND/2)
    localparam int CORE_LAT = 14;   // core cycles from core_start to valid core_c

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // One-hot grant, bit i = requester i
    typedef logic [1:0] grant_t;
endpackage

// File: rtl/blink_sched_if.sv
// rtl/blink_sched_if.sv - request, key, core and result signals of the Blink scheduler
//   master: requesters, key loader, external core and result sink
//   slave : the scheduler itself
interface blink_sched_if;
    import blink_pkg::*;

    logic          req0_valid;
    logic          req0_ready;
    logic          req0_enc;
    logic [N-1:0]  req0_p;
    logic [TW-1:0] req0_t;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_enc;
    logic [N-1:0]  req1_p;
    logic [TW-1:0] req1_t;

    logic          key_wr;
    logic [KW-1:0] key_in;
    logic          key_ack;

    logic          core_start;
    logic          core_enc;
    logic [KW-1:0] core_k0;
    logic [N-1:0]  core_p;
    logic [TW-1:0] core_t;
    logic [N-1:0]  core_c;

    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  res_c;
    logic          res_id;

    modport master (
        output req0_valid, req0_enc, req0_p, req0_t,
        output req1_valid, req1_enc, req1_p, req1_t,
        output key_wr, key_in, core_c, res_ready,
        input  req0_ready, req1_ready, key_ack,
        input  core_start, core_enc, core_k0, core_p, core_t,
        input  res_valid, res_c, res_id
    );

    modport slave (
        input  req0_valid, req0_enc, req0_p, req0_t,
        input  req1_valid, req1_enc, req1_p, req1_t,
        input  key_wr, key_in, core_c, res_ready,
        output req0_ready, req1_ready, key_ack,
        output core_start, core_enc, core_k0, core_p, core_t,
        output res_valid, res_c, res_id
    );
endinterface

// File: rtl/blink_rr_arb.sv
// rtl/blink_rr_arb.sv - two-way round-robin grant
//   valid[1:0] : pending requests
//   last       : index of the most recently granted requester
//   grant[1:0] : one-hot grant (zero when nothing is valid)
module blink_rr_arb
    import blink_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output grant_t     grant
);
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie, favour whoever was not served last
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/blink_sched.sv
// rtl/blink_sched.sv - arbitrates two requesters onto one Blink core and holds the result
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requests 0/1, key load, external core handshake, result channel
module blink_sched #(
    parameter int N        = blink_pkg::N,
    parameter int TW       = blink_pkg::TW,
    parameter int KW       = blink_pkg::KW,
    parameter int CORE_LAT = blink_pkg::CORE_LAT
) (
    input  logic         clk,
    input  logic         rst,
    blink_sched_if.slave bus
);
    import blink_pkg::*;

    localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CORE_LAT - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          last;
    grant_t        grant;
    logic          idle;
    logic          accept;
    logic          sel;

    logic          enc_q;
    logic [N-1:0]  p_q;
    logic [TW-1:0] t_q;
    logic [KW-1:0] k0_q;
    logic [N-1:0]  res_c_q;
    logic          res_id_q;

    blink_rr_arb u_arb (
        .valid ({bus.req1_valid, bus.req0_valid}),
        .last  (last),
        .grant (grant)
    );

    // A key write in IDLE takes the cycle; requests wait until it drops
    assign idle   = (state == ST_IDLE);
    assign accept = idle && !bus.key_wr && (grant != 2'b00);
    assign sel    = grant[1];

    assign bus.key_ack    = idle && bus.key_wr;
    assign bus.req0_ready = accept && grant[0];
    assign bus.req1_ready = accept && grant[1];
    assign bus.core_start = (state == ST_RUN) && (cnt == '0);
    assign bus.core_enc   = enc_q;
    assign bus.core_p     = p_q;
    assign bus.core_t     = t_q;
    assign bus.core_k0    = k0_q;
    assign bus.res_valid  = (state == ST_HOLD);
    assign bus.res_c      = res_c_q;
    assign bus.res_id     = res_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            enc_q    <= 1'b0;
            p_q      <= '0;
            t_q      <= '0;
            k0_q     <= '0;
            res_c_q  <= '0;
            res_id_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.key_wr) begin
                        k0_q <= bus.key_in;
                    end else if (accept) begin
                        enc_q    <= sel ? bus.req1_enc : bus.req0_enc;
                        p_q      <= sel ? bus.req1_p   : bus.req0_p;
                        t_q      <= sel ? bus.req1_t   : bus.req0_t;
                        res_id_q <= sel;
                        last     <= sel;
                        cnt      <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt == LAST_CNT) begin
                        res_c_q <= bus.core_c;
                        state   <= ST_HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.res_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/blink_sched.md
BLINK_SCHED -- requirements
Module: blink_sched

Interface
REQ-001 SHALL have parameter N, 64, block width in bits.
REQ-002 SHALL have parameter TW, 64, tweak width in bits.
REQ-003 SHALL have parameter KW, 448, round-key bundle width (N*ROUND/2).
REQ-004 SHALL have parameter CORE_LAT, 14, core cycles from core_start to valid core_c.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have ports reqX_valid  in  1  request valid, X=0,1.
REQ-008 SHALL have ports reqX_ready  out  1  request accepted this cycle, X=0,1.
REQ-009 SHALL have ports reqX_enc  in  1  1=encrypt, 0=decrypt, X=0,1.
REQ-010 SHALL have ports reqX_p  in  N  input block, X=0,1.
REQ-011 SHALL have ports reqX_t  in  TW  tweak, X=0,1.
REQ-012 SHALL have ports key_wr  in  1 and key_in  in  KW; key_ack  out  1  key load accepted this cycle.
REQ-013 SHALL have ports core_start  out  1; core_enc  out  1; core_k0  out  KW; core_p  out  N; core_t  out  TW; core_c  in  N (Blink core, external).
REQ-014 SHALL have ports res_valid  out  1; res_ready  in  1; res_c  out  N; res_id  out  1 (winning requester index).

Function
REQ-015 SHALL implement FSM IDLE, RUN, HOLD; reset state IDLE.
REQ-016 In IDLE with key_wr=1, SHALL assert key_ack combinationally, load key_in into core_k0 at the clock edge, and hold both reqX_ready low.
REQ-017 key_wr outside IDLE SHALL be ignored: key_ack=0, core_k0 unchanged.
REQ-018 In IDLE with key_wr=0 and some reqX_valid=1, SHALL assert exactly one reqX_ready (combinational) and register that requester's enc/p/t into core_enc/core_p/core_t and its index into res_id; next state RUN, counter=0.
REQ-019 Arbitration SHALL be round-robin: sole valid wins; both valid -> grant the requester not granted last; last-grant register resets to 1 (req0 wins first tie).
REQ-020 core_start SHALL be high only in the first RUN cycle (counter=0).
REQ-021 RUN SHALL last exactly CORE_LAT cycles (counter 0..CORE_LAT-1); at the edge ending counter=CORE_LAT-1, SHALL capture core_c into res_c and enter HOLD.
REQ-022 res_valid SHALL equal (state==HOLD); res_c/res_id stable while res_valid=1 and res_ready=0.
REQ-023 In HOLD, res_ready=1 SHALL complete the transfer and return to IDLE; no new request accepted in that cycle.
REQ-024 core_enc/core_p/core_t SHALL remain stable from acceptance until return to IDLE.
REQ-025 reqX_ready SHALL be 0 in RUN and HOLD regardless of reqX_valid.
REQ-026 Counter width SHALL be clog2(CORE_LAT); no wrap beyond CORE_LAT-1.

Reset
REQ-027 rst=1 SHALL asynchronously force: state IDLE, counter 0, last-grant 1, res_valid 0, res_c 0, res_id 0, core_start 0, core_enc 0, core_p 0, core_t 0, core_k0 0.
REQ-028 rst asserted during RUN or HOLD SHALL discard the in-flight operation; no result emitted after release.

Structure
REQ-029 N, TW, KW, CORE_LAT and FSM state encodings SHALL reside in shared package blink_pkg.
REQ-030 Round-robin grant logic SHALL be sub-module blink_rr_arb (inputs valid[1:0], last; output grant[1:0]).

Verification
REQ-031 Single request: req0 enc=1, p=0x0123456789ABCDEF, t=0x0, res_ready=1 -> req0_ready 1 cycle; core_start 1 cycle later; res_valid CORE_LAT+1 cycles after acceptance, res_c = reference-model ciphertext, res_id=0.
REQ-032 Contention: req0, req1 valid continuously for 4 transactions -> grants 0,1,0,1; res_id matches each.
REQ-033 Backpressure: res_ready=0 for 10 cycles in HOLD -> res_valid/res_c/res_id stable; both readies 0; completes on res_ready=1.
REQ-034 Key: key_wr with key_in=all 0xA5 in IDLE -> key_ack=1, core_k0 updated; key_wr during RUN -> key_ack=0, core_k0 unchanged; key_wr with req0_valid in IDLE -> key wins, req0 accepted next cycle.
REQ-035 Reset mid-RUN at counter=5 -> all outputs reset values immediately; no res_valid after release until new request.
REQ-036 Round trip: encrypt then decrypt result with same tweak -> res_c equals original plaintext.
